tank_bullet: RTL and testbench
==============================

# tank_bullet

Bullet engine for one tank. It launches a bullet when the tank's controller issues a fire pulse and tracks the bullet across the 640×480 playfield in fixed steps. It detects a hit on the opposing tank's bounding box, retires the bullet at the screen edge, and optionally holds a short explosion phase. It sits directly downstream of the AI/player tank controller: it consumes that controller's fire bit and bullet orientation, and returns `bullet_act`, which the controller uses to block re-fire.

## Interface
Parameters:
- `STEP_CNT`, default 250000: clk cycles per bullet step tick.
- `STEP_PX`, default 2: pixels moved per step.
- `X_MAX`, default 639: last visible column.
- `Y_MAX`, default 479: last visible row.
- `TANK_W`, default 32: tank box edge, in pixels.
- `BULLET_W`, default 4: bullet box edge, in pixels.
- `EXPLODE_STEPS`, default 8: step ticks spent in EXPLODE.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock `clk`.
- `fire` in 1: fire request, one-cycle pulse (controller fire bit).
- `bullet_orient` in 2: 00 up, 01 down, 10 left, 11 right.
- `x_shooter` in 10, `y_shooter` in 9: shooter tank top-left corner.
- `x_target` in 10, `y_target` in 9: opposing tank top-left corner.
- `bullet_act` out 1: bullet in flight or exploding.
- `x_bullet` out 10, `y_bullet` out 9: bullet top-left corner.
- `hit` out 1: one-cycle pulse when the target is struck.
- `exploding` out 1: high during EXPLODE.

## Operation
- Reset values: state IDLE, `bullet_act`=0, `x_bullet`=0, `y_bullet`=0, `hit`=0, `exploding`=0, step counter=0.
- IDLE
  - `fire`=1 → ARM.
  - `fire` in any other state is ignored; it is not queued.
- ARM (exactly 1 cycle)
  - Latches `bullet_orient`. The controller updates its orientation register on the same edge as `fire`, so orientation is read one cycle later.
  - Spawn point, with c = TANK_W/2 − BULLET_W/2:
    - up: (xs+c, ys−BULLET_W)
    - down: (xs+c, ys+TANK_W)
    - left: (xs−BULLET_W, ys+c)
    - right: (xs+TANK_W, ys+c)
  - Spawn arithmetic is 11-bit signed. If the spawn point is off screen (negative, or far edge > X_MAX/Y_MAX), go to IDLE with no flight.
  - Otherwise set `bullet_act`=1 and go to FLIGHT.
- FLIGHT
  - Hit check every cycle: axis-aligned overlap of the BULLET_W box against the target's TANK_W box (inclusive edges).
  - On overlap: `hit`=1 for one cycle, then EXPLODE.
  - On a step tick with no overlap, edge check against the next position:
    - up: y < STEP_PX
    - down: y+BULLET_W−1+STEP_PX > Y_MAX
    - left: x < STEP_PX
    - right: x+BULLET_W−1+STEP_PX > X_MAX
  - Edge condition true → IDLE (miss), `bullet_act`=0. Otherwise move STEP_PX.
  - Hit and edge in the same cycle: hit wins.
- EXPLODE
  - `exploding`=1, `bullet_act` stays 1, position frozen.
  - After EXPLODE_STEPS step ticks → IDLE, clearing `bullet_act` and `exploding`.
- Step tick
  - Free-running counter 0..STEP_CNT−1; tick pulses when it wraps to 0.
  - The counter is not realigned on fire.
- Position registers hold their last value in IDLE.

## Timing
- `fire` at edge n → ARM at n+1 → FLIGHT with `bullet_act`=1 at n+2.
- The first move occurs on the first tick after entering FLIGHT.
- `hit` is registered: asserted the cycle after the overlap is visible on the inputs.
- `bullet_act` falls in the same cycle the state returns to IDLE. A `fire` pulse in that same cycle is ignored; `fire` is sampled only in IDLE.
- Reset mid-flight or mid-explosion: IDLE next edge, with all outputs at reset values.

## Configuration
- `TANK_BULLET_EXPLODE_EN` defined: EXPLODE state present as above.
- Not defined:
  - A hit goes FLIGHT → IDLE directly (`hit` still pulses, `bullet_act` clears the cycle after `hit`).
  - `exploding` is tied 0.
  - `EXPLODE_STEPS` is unused.

## Structure
- Shared package `tank_pkg` holds:
  - orientation codes `ICON_UP`/`ICON_DOWN`/`ICON_LEFT`/`ICON_RIGHT` (2'b00/01/10/11)
  - screen constants X_MAX/Y_MAX
  - TANK_W
  - the bullet state enum (IDLE, ARM, FLIGHT, EXPLODE)
- Sub-module `tick_gen` (parameter PERIOD) produces the step tick. It is reusable by the tank movement logic.

## Test plan
- Shooter (100,200), orient up, target far away, STEP_CNT=4:
  - spawn (114,196)
  - y decreases by 2 per tick
  - `bullet_act` falls when y < 2
  - `hit` never asserts.
- Orient right, shooter (300,100), target (400,100):
  - `hit` pulses exactly once when x_bullet+3 ≥ 400
  - EXPLODE for 8 ticks, then `bullet_act`=0.
- Second `fire` during FLIGHT and during EXPLODE: ignored; position trajectory unchanged.
- Shooter (10,10), orient left: spawn x = 6, flight proceeds; shooter (2,10), orient left: spawn negative → ARM→IDLE, `bullet_act` pulses at most 0 cycles.
- Reset asserted mid-flight at (250,250): next cycle `bullet_act`=0, `x_bullet`=0, `y_bullet`=0, `hit`=0; a new `fire` then launches normally.
- Macro undefined, hit scenario: `hit`=1, then `bullet_act`=0 next cycle, `exploding` stays 0.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared tank-game definitions: orientation codes, screen geometry and the bullet state encoding.
package tank_pkg;

    localparam logic [1:0] ICON_UP    = 2'b00;
    localparam logic [1:0] ICON_DOWN  = 2'b01;
    localparam logic [1:0] ICON_LEFT  = 2'b10;
    localparam logic [1:0] ICON_RIGHT = 2'b11;

    localparam int X_MAX  = 639;
    localparam int Y_MAX  = 479;
    localparam int TANK_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARM     = 2'b01,
        FLIGHT  = 2'b10,
        EXPLODE = 2'b11
    } bullet_state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every PERIOD clocks; shared with tank movement.
module tick_gen #(
    parameter int PERIOD = 250000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Count 0..PERIOD-1; tick is registered so it is high while the count reads zero after a wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == CW'(PERIOD - 1)) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/tank_bullet.sv
// Single-bullet engine: launch on fire, step across the playfield, detect hits and edge exits.
// Define TANK_BULLET_EXPLODE_EN to hold the bullet in an EXPLODE phase after a hit.
module tank_bullet #(
    parameter int STEP_CNT      = 250000,
    parameter int STEP_PX       = 2,
    parameter int X_MAX         = tank_pkg::X_MAX,
    parameter int Y_MAX         = tank_pkg::Y_MAX,
    parameter int TANK_W        = tank_pkg::TANK_W,
    parameter int BULLET_W      = 4,
    parameter int EXPLODE_STEPS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire,
    input  logic [1:0] bullet_orient,
    input  logic [9:0] x_shooter,
    input  logic [8:0] y_shooter,
    input  logic [9:0] x_target,
    input  logic [8:0] y_target,
    output logic       bullet_act,
    output logic [9:0] x_bullet,
    output logic [8:0] y_bullet,
    output logic       hit,
    output logic       exploding
);
    import tank_pkg::*;

    localparam int C_OFS = TANK_W / 2 - BULLET_W / 2;

    bullet_state_t      state_r, state_s;
    logic [9:0]         x_r, x_s;
    logic [8:0]         y_r, y_s;
    logic [1:0]         dir_r, dir_s;
    logic               act_r, act_s;
    logic               hit_r, hit_s;
    logic               tick_s;
    logic signed [10:0] xs_s, ys_s, spawn_x_s, spawn_y_s;
    logic               spawn_ok_s, overlap_s, edge_s;
    logic [11:0]        bx_s, by_s, tx_s, ty_s;

`ifdef TANK_BULLET_EXPLODE_EN
    localparam int EW = (EXPLODE_STEPS > 1) ? $clog2(EXPLODE_STEPS) : 1;
    logic [EW-1:0] ecnt_r, ecnt_s;
    logic          exp_r, exp_s;
`else
    localparam int unused_explode_steps = EXPLODE_STEPS;
`endif

    tick_gen #(.PERIOD(STEP_CNT)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    assign xs_s = $signed({1'b0, x_shooter});
    assign ys_s = $signed({2'b00, y_shooter});
    assign bx_s = {2'b00, x_r};
    assign by_s = {3'b000, y_r};
    assign tx_s = {2'b00, x_target};
    assign ty_s = {3'b000, y_target};

    // Geometry: spawn point (signed, so off-screen shows as negative), target overlap, edge look-ahead.
    always_comb begin
        spawn_x_s = xs_s + 11'(C_OFS);
        spawn_y_s = ys_s + 11'(C_OFS);
        case (bullet_orient)
            ICON_UP:    spawn_y_s = ys_s - 11'(BULLET_W);
            ICON_DOWN:  spawn_y_s = ys_s + 11'(TANK_W);
            ICON_LEFT:  spawn_x_s = xs_s - 11'(BULLET_W);
            ICON_RIGHT: spawn_x_s = xs_s + 11'(TANK_W);
            default:    spawn_x_s = xs_s + 11'(C_OFS);
        endcase
        spawn_ok_s = !spawn_x_s[10] && !spawn_y_s[10]
                     && ({1'b0, spawn_x_s} + 12'(BULLET_W - 1) <= 12'(X_MAX))
                     && ({1'b0, spawn_y_s} + 12'(BULLET_W - 1) <= 12'(Y_MAX));

        overlap_s = (bx_s <= tx_s + 12'(TANK_W - 1)) && (tx_s <= bx_s + 12'(BULLET_W - 1))
                    && (by_s <= ty_s + 12'(TANK_W - 1)) && (ty_s <= by_s + 12'(BULLET_W - 1));

        case (dir_r)
            ICON_UP:    edge_s = by_s < 12'(STEP_PX);
            ICON_DOWN:  edge_s = by_s + 12'(BULLET_W - 1 + STEP_PX) > 12'(Y_MAX);
            ICON_LEFT:  edge_s = bx_s < 12'(STEP_PX);
            ICON_RIGHT: edge_s = bx_s + 12'(BULLET_W - 1 + STEP_PX) > 12'(X_MAX);
            default:    edge_s = 1'b1;
        endcase
    end

    // Next-state and next-output logic; a hit takes priority over the edge/move decision.
    always_comb begin
        state_s = state_r;
        x_s     = x_r;
        y_s     = y_r;
        dir_s   = dir_r;
        act_s   = act_r;
        hit_s   = 1'b0;
`ifdef TANK_BULLET_EXPLODE_EN
        ecnt_s  = ecnt_r;
        exp_s   = exp_r;
`endif
        case (state_r)
            IDLE: begin
                act_s = 1'b0;
`ifdef TANK_BULLET_EXPLODE_EN
                exp_s = 1'b0;
`endif
                if (fire) begin
                    state_s = ARM;
                end else begin
                    state_s = IDLE;
                end
            end
            ARM: begin
                dir_s = bullet_orient;
                if (spawn_ok_s) begin
                    x_s     = spawn_x_s[9:0];
                    y_s     = spawn_y_s[8:0];
                    act_s   = 1'b1;
                    state_s = FLIGHT;
                end else begin
                    state_s = IDLE;
                end
            end
            FLIGHT: begin
`ifdef TANK_BULLET_EXPLODE_EN
                if (overlap_s) begin
                    hit_s   = 1'b1;
                    exp_s   = 1'b1;
                    ecnt_s  = '0;
                    state_s = EXPLODE;
                end
`else
                // The cycle showing the hit pulse retires the bullet without moving it.
                if (hit_r) begin
                    act_s   = 1'b0;
                    state_s = IDLE;
                end else if (overlap_s) begin
                    hit_s = 1'b1;
                end
`endif
                else if (tick_s) begin
                    if (edge_s) begin
                        act_s   = 1'b0;
                        state_s = IDLE;
                    end else begin
                        case (dir_r)
                            ICON_UP:    y_s = y_r - 9'(STEP_PX);
                            ICON_DOWN:  y_s = y_r + 9'(STEP_PX);
                            ICON_LEFT:  x_s = x_r - 10'(STEP_PX);
                            ICON_RIGHT: x_s = x_r + 10'(STEP_PX);
                            default:    x_s = x_r;
                        endcase
                    end
                end else begin
                    state_s = FLIGHT;
                end
            end
            EXPLODE: begin
`ifdef TANK_BULLET_EXPLODE_EN
                if (tick_s) begin
                    if (ecnt_r == EW'(EXPLODE_STEPS - 1)) begin
                        act_s   = 1'b0;
                        exp_s   = 1'b0;
                        state_s = IDLE;
                    end else begin
                        ecnt_s = ecnt_r + EW'(1);
                    end
                end else begin
                    state_s = EXPLODE;
                end
`else
                act_s   = 1'b0;
                state_s = IDLE;
`endif
            end
            default: begin
                act_s   = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            x_r     <= 10'd0;
            y_r     <= 9'd0;
            dir_r   <= 2'b00;
            act_r   <= 1'b0;
            hit_r   <= 1'b0;
`ifdef TANK_BULLET_EXPLODE_EN
            ecnt_r  <= '0;
            exp_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            x_r     <= x_s;
            y_r     <= y_s;
            dir_r   <= dir_s;
            act_r   <= act_s;
            hit_r   <= hit_s;
`ifdef TANK_BULLET_EXPLODE_EN
            ecnt_r  <= ecnt_s;
            exp_r   <= exp_s;
`endif
        end
    end

    assign bullet_act = act_r;
    assign x_bullet   = x_r;
    assign y_bullet   = y_r;
    assign hit        = hit_r;
`ifdef TANK_BULLET_EXPLODE_EN
    assign exploding  = exp_r;
`else
    assign exploding  = 1'b0;
`endif

endmodule

// File: tb/tb_tank_bullet.sv
// Randomized bench for tank_bullet with a cycle-level behavioural reference and directed literal checks.
`timescale 1ns/1ps
module tb_tank_bullet;

    localparam int STEP_CNT = 4, STEP_PX = 2, X_MAX = 639, Y_MAX = 479;
    localparam int TANK_W = 32, BULLET_W = 4, EXPLODE_STEPS = 8;
    localparam int M_IDLE = 0, M_ARM = 1, M_FLIGHT = 2, M_HITDONE = 3, M_EXPLODE = 4;

    logic       clk = 1'b0, reset = 1'b1, fire = 1'b0;
    logic [1:0] orient = 2'b00;
    logic [9:0] x_shooter = 10'd0, x_target = 10'd600;
    logic [8:0] y_shooter = 9'd0, y_target = 9'd400;
    logic       bullet_act, hit, exploding;
    logic [9:0] x_bullet;
    logic [8:0] y_bullet;

    int checks = 0, errors = 0, hit_cnt = 0, n_edges = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        int mode; int x; int y; int dir; int ecnt;
        bit act; bit hit; bit exp;
    } mstate_t;
    mstate_t m = '0;

    tank_bullet #(
        .STEP_CNT(STEP_CNT), .STEP_PX(STEP_PX), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
        .TANK_W(TANK_W), .BULLET_W(BULLET_W), .EXPLODE_STEPS(EXPLODE_STEPS)
    ) dut (
        .clk(clk), .reset(reset), .fire(fire), .bullet_orient(orient),
        .x_shooter(x_shooter), .y_shooter(y_shooter),
        .x_target(x_target), .y_target(y_target),
        .bullet_act(bullet_act), .x_bullet(x_bullet), .y_bullet(y_bullet),
        .hit(hit), .exploding(exploding)
    );

    always #5 clk = ~clk;

    // Reference: what the bullet must do next, from the game rules in plain integer geometry.
    function automatic mstate_t model_next(mstate_t s, bit rst, bit f, int o, int xs, int ys,
                                           int xt, int yt, bit tk);
        mstate_t r;
        int c, sx, sy, dx, dy;
        bit ov, at_edge;
        r = s;
        r.hit = 1'b0;
        c = TANK_W / 2 - BULLET_W / 2;
        ov = (s.x <= xt + TANK_W - 1) && (xt <= s.x + BULLET_W - 1) &&
             (s.y <= yt + TANK_W - 1) && (yt <= s.y + BULLET_W - 1);
        dx = (s.dir == 2) ? -STEP_PX : (s.dir == 3) ? STEP_PX : 0;
        dy = (s.dir == 0) ? -STEP_PX : (s.dir == 1) ? STEP_PX : 0;
        at_edge = (s.x + dx < 0) || (s.y + dy < 0) ||
                  (s.x + dx + BULLET_W - 1 > X_MAX) || (s.y + dy + BULLET_W - 1 > Y_MAX);
        if (rst) begin
            r = '0;
        end else begin
            case (s.mode)
                M_IDLE: if (f) r.mode = M_ARM;
                M_ARM: begin
                    r.dir = o;
                    sx = (o == 2) ? xs - BULLET_W : (o == 3) ? xs + TANK_W : xs + c;
                    sy = (o == 0) ? ys - BULLET_W : (o == 1) ? ys + TANK_W : ys + c;
                    if (sx < 0 || sy < 0 || sx + BULLET_W - 1 > X_MAX || sy + BULLET_W - 1 > Y_MAX)
                        r.mode = M_IDLE;
                    else begin
                        r.mode = M_FLIGHT; r.x = sx; r.y = sy; r.act = 1'b1;
                    end
                end
                M_FLIGHT: begin
                    if (ov) begin
                        r.hit = 1'b1;
`ifdef TANK_BULLET_EXPLODE_EN
                        r.mode = M_EXPLODE; r.exp = 1'b1; r.ecnt = 0;
`else
                        r.mode = M_HITDONE;
`endif
                    end else if (tk) begin
                        if (at_edge) begin
                            r.mode = M_IDLE; r.act = 1'b0;
                        end else begin
                            r.x = s.x + dx; r.y = s.y + dy;
                        end
                    end
                end
                M_HITDONE: begin
                    r.mode = M_IDLE; r.act = 1'b0;
                end
                M_EXPLODE: begin
                    if (tk) begin
                        r.ecnt = s.ecnt + 1;
                        if (r.ecnt == EXPLODE_STEPS) begin
                            r.mode = M_IDLE; r.act = 1'b0; r.exp = 1'b0;
                        end
                    end
                end
                default: r.mode = M_IDLE;
            endcase
        end
        return r;
    endfunction

    // Advance the reference on each edge; ticks land every STEP_CNT edges after reset release.
    always @(posedge clk) begin
        m <= model_next(m, reset, fire, int'(orient), int'(x_shooter), int'(y_shooter),
                        int'(x_target), int'(y_target),
                        (n_edges > 0) && (n_edges % STEP_CNT == 0));
        n_edges <= reset ? 0 : n_edges + 1;
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("bullet_act", int'(bullet_act), int'(m.act));
            check("x_bullet",   int'(x_bullet),   m.x);
            check("y_bullet",   int'(y_bullet),   m.y);
            check("hit",        int'(hit),        int'(m.hit));
            check("exploding",  int'(exploding),  int'(m.exp));
        end
        if (hit) hit_cnt++;
    end

    task automatic pulse_fire(input int o);
        @(negedge clk);
        fire = 1'b1;
        orient = 2'(o);
        @(negedge clk);
        fire = 1'b0;
    endtask

    task automatic wait_act(input bit want, input int budget, input string name);
        int c = 0;
        while (bullet_act !== want && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, int'(bullet_act), int'(want));
    endtask

    task automatic place(input int xs, input int ys, input int xt, input int yt);
        x_shooter = 10'(xs); y_shooter = 9'(ys);
        x_target  = 10'(xt); y_target  = 9'(yt);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int act_seen, cyc, xs, ys, xt, yt, o, d;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_act", int'(bullet_act), 0);
        check("reset_x", int'(x_bullet), 0);
        check("reset_hit", int'(hit), 0);
        @(negedge clk);
        reset = 1'b0;

        // Up from (100,200), far target; a second fire mid-flight must not disturb it.
        place(100, 200, 600, 400);
        hit_cnt = 0;
        pulse_fire(0);
        wait_act(1'b1, 4, "A_launch");
        check("A_spawn_x", int'(x_bullet), 114);
        check("A_spawn_y", int'(y_bullet), 196);
        repeat (40) @(negedge clk);
        pulse_fire(2);
        wait_act(1'b0, 2000, "A_retire");
        check("A_final_y", int'(y_bullet), 0);
        check("A_final_x", int'(x_bullet), 114);
        check("A_no_hit", hit_cnt, 0);

        // Right from (300,100) into target (400,100).
        place(300, 100, 400, 100);
        hit_cnt = 0;
        pulse_fire(3);
        wait_act(1'b1, 4, "B_launch");
        check("B_spawn_x", int'(x_bullet), 332);
        cyc = 0;
        while (hit !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("B_hit_seen", int'(hit), 1);
        check("B_hit_x", int'(x_bullet), 398);
`ifdef TANK_BULLET_EXPLODE_EN
        check("B_exploding", int'(exploding), 1);
        pulse_fire(0);
        wait_act(1'b0, 200, "B_explode_end");
        check("B_explode_clear", int'(exploding), 0);
`else
        @(negedge clk);
        check("B_act_after_hit", int'(bullet_act), 0);
        check("B_no_explode", int'(exploding), 0);
`endif
        repeat (5) @(negedge clk);
        check("B_one_hit", hit_cnt, 1);
        check("B_x_held", int'(x_bullet), 398);

        // Left near the edge: valid spawn at x=6, then an off-screen spawn that never flies.
        place(10, 10, 600, 400);
        pulse_fire(2);
        wait_act(1'b1, 4, "D_launch");
        check("D_spawn_x", int'(x_bullet), 6);
        check("D_spawn_y", int'(y_bullet), 24);
        wait_act(1'b0, 200, "D_retire");
        check("D_final_x", int'(x_bullet), 0);
        place(2, 10, 600, 400);
        pulse_fire(2);
        act_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bullet_act) act_seen++;
        end
        check("D_offscreen_act", act_seen, 0);
        check("D_hold_y", int'(y_bullet), 24);

        // Reset mid-flight, then a clean relaunch.
        place(236, 218, 600, 10);
        pulse_fire(1);
        wait_act(1'b1, 4, "E_launch");
        check("E_spawn_y", int'(y_bullet), 250);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("E_rst_act", int'(bullet_act), 0);
        check("E_rst_x", int'(x_bullet), 0);
        check("E_rst_y", int'(y_bullet), 0);
        check("E_rst_hit", int'(hit), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        pulse_fire(1);
        wait_act(1'b1, 4, "E_relaunch");
        check("E_relaunch_x", int'(x_bullet), 250);
        wait_act(1'b0, 2000, "E_retire");

        // Random launches with targets often placed in the line of fire and stray fire/orient noise.
        for (int k = 0; k < 20; k++) begin
            xs = $urandom_range(0, 607);
            ys = $urandom_range(0, 447);
            o  = $urandom_range(0, 3);
            d  = $urandom_range(40, 250);
            xt = $urandom_range(0, 607);
            yt = $urandom_range(0, 447);
            if ($urandom_range(0, 2) != 0) begin
                xt = (o == 2) ? xs - d : (o == 3) ? xs + d : xs;
                yt = (o == 0) ? ys - d : (o == 1) ? ys + d : ys;
            end
            xt = (xt < 0) ? 0 : (xt > 607) ? 607 : xt;
            yt = (yt < 0) ? 0 : (yt > 447) ? 447 : yt;
            place(xs, ys, xt, yt);
            pulse_fire(o);
            @(negedge clk);
            cyc = 0;
            while (bullet_act && cyc < 3000) begin
                fire = ($urandom_range(0, 9) == 0);
                orient = 2'($urandom_range(0, 3));
                @(negedge clk);
                cyc++;
            end
            fire = 1'b0;
            repeat (3) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
